// File: rtl/fu_muldiv.sv
// rtl/fu_muldiv.sv - iterative RV32M multiply/divide unit (shift-add multiplier, restoring divider)
// Optional zero/divide-by-zero/overflow early-out enabled by FU_MULDIV_EARLY_OUT_EN.
module fu_muldiv #(
   parameter int XLEN               = 32,
   parameter int MUL_BITS_PER_CYCLE = 2,
   parameter int PHYS_REG_BITS      = 6,
   parameter int ROB_IDX_BITS       = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_funct3,
   input  logic [XLEN-1:0]          rs1_v,
   input  logic [XLEN-1:0]          rs2_v,
   input  logic [PHYS_REG_BITS-1:0] in_pd,
   input  logic [ROB_IDX_BITS-1:0]  in_rob,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_rd_v,
   output logic [PHYS_REG_BITS-1:0] out_pd,
   output logic [ROB_IDX_BITS-1:0]  out_rob,
   input  logic                     global_branch_signal
);

   localparam int MB    = MUL_BITS_PER_CYCLE;
   localparam int N_MUL = XLEN / MB;
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [1:0]               op_q, op_d;
   logic [PHYS_REG_BITS-1:0] pd_q, pd_d;
   logic [ROB_IDX_BITS-1:0]  rob_q, rob_d;
   logic [XLEN-1:0]          a_q, a_d;
   logic [XLEN-1:0]          b_q, b_d;
   logic                     neg_q, neg_d;
   logic [2*XLEN-1:0]        acc_q, acc_d;
   logic [XLEN:0]            rem_q, rem_d;
   logic [XLEN-1:0]          quo_q, quo_d;
   logic [XLEN-1:0]          res_q, res_d;

   // Operand decode at issue: magnitudes plus the single negation the final result needs.
   logic            in_is_div, in_a_signed, in_b_signed, in_a_neg, in_b_neg;
   logic            in_b_zero, in_neg, accept;
   logic [XLEN-1:0] in_a_mag, in_b_mag;

   always_comb begin
      in_is_div   = in_funct3[2];
      in_a_signed = in_is_div ? ~in_funct3[0] : (in_funct3[1:0] != 2'b11);
      in_b_signed = in_is_div ? ~in_funct3[0] : ~in_funct3[1];
      in_a_neg    = in_a_signed & rs1_v[XLEN-1];
      in_b_neg    = in_b_signed & rs2_v[XLEN-1];
      in_a_mag    = in_a_neg ? -rs1_v : rs1_v;
      in_b_mag    = in_b_neg ? -rs2_v : rs2_v;
      in_b_zero   = (rs2_v == '0);
      if (!in_is_div) begin
         in_neg = in_a_neg ^ in_b_neg;
      end else if (in_funct3[1]) begin
         in_neg = in_a_neg;
      end else begin
         in_neg = (in_a_neg ^ in_b_neg) & ~in_b_zero;
      end
      accept = (state_q == S_IDLE) & in_valid & ~global_branch_signal;
   end

`ifdef FU_MULDIV_EARLY_OUT_EN
   logic            early_hit;
   logic [XLEN-1:0] early_res;

   always_comb begin
      early_hit = 1'b0;
      early_res = '0;
      if (in_is_div) begin
         if (in_b_zero) begin
            early_hit = 1'b1;
            early_res = in_funct3[1] ? rs1_v : '1;
         end else if (!in_funct3[0] && (rs1_v == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_v)) begin
            early_hit = 1'b1;
            early_res = in_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
         end
      end else if ((rs1_v == '0) || in_b_zero) begin
         early_hit = 1'b1;
         early_res = '0;
      end
   end
`endif

   // Multiplier: accumulator holds {partial product high, remaining multiplier bits}.
   logic [XLEN+MB-1:0] mul_pp, mul_sum;
   logic [2*XLEN-1:0]  mul_next, mul_fix;

   always_comb begin
      mul_pp = '0;
      for (int j = 0; j < MB; j++) begin
         if (acc_q[j]) begin
            mul_pp = mul_pp + ({{MB{1'b0}}, a_q} << j);
         end
      end
      mul_sum  = {{MB{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mul_pp;
      mul_next = {mul_sum, acc_q[XLEN-1:MB]};
      mul_fix  = neg_q ? -mul_next : mul_next;
   end

   // Restoring divider: quo_q shifts the dividend out and the quotient in.
   logic [XLEN+1:0] div_shift, div_diff;
   logic            div_ge;
   logic [XLEN:0]   rem_next;
   logic [XLEN-1:0] quo_next, quo_fix, rem_fix;

   always_comb begin
      div_shift = {rem_q, quo_q[XLEN-1]};
      div_diff  = div_shift - {2'b00, b_q};
      div_ge    = ~div_diff[XLEN+1];
      rem_next  = div_ge ? div_diff[XLEN:0] : div_shift[XLEN:0];
      quo_next  = {quo_q[XLEN-2:0], div_ge};
      quo_fix   = neg_q ? -quo_next : quo_next;
      rem_fix   = neg_q ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      pd_d    = pd_q;
      rob_d   = rob_q;
      a_d     = a_q;
      b_d     = b_q;
      neg_d   = neg_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = in_funct3[1:0];
               pd_d    = in_pd;
               rob_d   = in_rob;
               a_d     = in_a_mag;
               b_d     = in_b_mag;
               neg_d   = in_neg;
               cnt_d   = '0;
               acc_d   = {{XLEN{1'b0}}, in_b_mag};
               rem_d   = '0;
               quo_d   = in_a_mag;
               state_d = in_is_div ? S_DIV : S_MUL;
`ifdef FU_MULDIV_EARLY_OUT_EN
               if (early_hit) begin
                  res_d   = early_res;
                  state_d = S_DONE;
               end
`endif
            end
         end
         S_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N_MUL - 1)) begin
               acc_d   = mul_fix;
               res_d   = (op_q == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
               state_d = S_DONE;
            end
         end
         S_DIV: begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) begin
               res_d   = op_q[1] ? rem_fix : quo_fix;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A flush wins over everything, including a DONE handshake in the same cycle.
      if (global_branch_signal) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         pd_q    <= '0;
         rob_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         pd_q    <= pd_d;
         rob_q   <= rob_d;
         a_q     <= a_d;
         b_q     <= b_d;
         neg_q   <= neg_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_rd_v  = res_q;
   assign out_pd    = pd_q;
   assign out_rob   = rob_q;

endmodule

// File: tb/tb_fu_muldiv.sv
// tb/tb_fu_muldiv.sv - directed and randomised scoreboard bench for fu_muldiv
module tb_fu_muldiv;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_funct3;
   logic [31:0] rs1_v;
   logic [31:0] rs2_v;
   logic [5:0]  in_pd;
   logic [4:0]  in_rob;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rd_v;
   logic [5:0]  out_pd;
   logic [4:0]  out_rob;
   logic        global_branch_signal;

   fu_muldiv dut (
      .clk                  (clk),
      .rst                  (rst),
      .in_valid             (in_valid),
      .in_ready             (in_ready),
      .in_funct3            (in_funct3),
      .rs1_v                (rs1_v),
      .rs2_v                (rs2_v),
      .in_pd                (in_pd),
      .in_rob               (in_rob),
      .out_valid            (out_valid),
      .out_ready            (out_ready),
      .out_rd_v             (out_rd_v),
      .out_pd               (out_pd),
      .out_rob              (out_rob),
      .global_branch_signal (global_branch_signal)
   );

   typedef struct {
      logic [31:0] res;
      logic [5:0]  pd;
      logic [4:0]  rob;
      int          t_acc;
      int          lat;
   } exp_t;

   exp_t scb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Reference RV32M semantics computed with 64-bit arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      longint      sa, sbv;
      int          ia, ib;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ia  = a;
      ib  = b;
      case (f3)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = 64'(sa * sbv); return p[63:32]; end
         3'd2: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(ia % ib);
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic special;
      special = f3[2] ? ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                      : ((a == 32'd0) || (b == 32'd0));
`ifdef FU_MULDIV_EARLY_OUT_EN
      if (special) return 1;
`else
      if (special && f3[2]) return 33;
`endif
      return f3[2] ? 33 : 17;
   endfunction

   task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] pd, input logic [4:0] rob);
      exp_t e;
      int   w;
      w = 0;
      while (!in_ready && w < 100) begin
         tick();
         w++;
      end
      check1("send_ready", in_ready, 1'b1);
      in_valid  = 1'b1;
      in_funct3 = f3;
      rs1_v     = a;
      rs2_v     = b;
      in_pd     = pd;
      in_rob    = rob;
      e.res     = model(f3, a, b);
      e.pd      = pd;
      e.rob     = rob;
      e.t_acc   = cyc;
      e.lat     = lat_of(f3, a, b);
      scb.push_back(e);
      tick();
      in_valid  = 1'b0;
      in_funct3 = 3'($urandom);
      rs1_v     = $urandom;
      rs2_v     = $urandom;
      in_pd     = 6'($urandom);
      in_rob    = 5'($urandom);
   endtask

   task automatic recv(input int hold, input string tag);
      exp_t e;
      int   w;
      w = 0;
      while (!out_valid && w < 200) begin
         tick();
         w++;
      end
      check1({tag, "_valid"}, out_valid, 1'b1);
      check1({tag, "_sb"}, scb.size() > 0, 1'b1);
      if (scb.size() > 0) begin
         e = scb.pop_front();
         check({tag, "_lat"}, 32'(cyc - e.t_acc), 32'(e.lat));
         check({tag, "_res"}, out_rd_v, e.res);
         check({tag, "_pd"}, {26'b0, out_pd}, {26'b0, e.pd});
         check({tag, "_rob"}, {27'b0, out_rob}, {27'b0, e.rob});
         for (int i = 0; i < hold; i++) begin
            tick();
            check1({tag, "_hold_valid"}, out_valid, 1'b1);
            check1({tag, "_hold_in_ready"}, in_ready, 1'b0);
            check({tag, "_hold_res"}, out_rd_v, e.res);
            check({tag, "_hold_pd"}, {26'b0, out_pd}, {26'b0, e.pd});
            check({tag, "_hold_rob"}, {27'b0, out_rob}, {27'b0, e.rob});
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check1({tag, "_post_valid"}, out_valid, 1'b0);
      check1({tag, "_post_in_ready"}, in_ready, 1'b1);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          w;
      logic        seen;
      rst = 1'b1;
      in_valid = 1'b0;
      in_funct3 = 3'd0;
      rs1_v = 32'd0;
      rs2_v = 32'd0;
      in_pd = 6'd0;
      in_rob = 5'd0;
      out_ready = 1'b0;
      global_branch_signal = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b0;
      check1("rst_in_ready", in_ready, 1'b1);
      check1("rst_out_valid", out_valid, 1'b0);
      check("rst_out_rd_v", out_rd_v, 32'd0);
      check("rst_out_pd", {26'b0, out_pd}, 32'd0);
      check("rst_out_rob", {27'b0, out_rob}, 32'd0);

      send(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 6'd5, 5'd3);
      recv(0, "mul");
      send(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd10, 5'd1);
      recv(0, "mulh");
      send(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 6'd11, 5'd2);
      recv(0, "mulhsu");
      send(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12, 5'd4);
      recv(0, "mulhu");

      send(3'd4, 32'hFFFF_FFF9, 32'd2, 6'd20, 5'd6);
      recv(0, "div_neg");
      send(3'd6, 32'hFFFF_FFF9, 32'd2, 6'd21, 5'd7);
      recv(0, "rem_neg");
      send(3'd5, 32'd7, 32'd0, 6'd22, 5'd8);
      recv(0, "divu_zero");
      send(3'd6, 32'd7, 32'd0, 6'd23, 5'd9);
      recv(0, "rem_zero");
      send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'd24, 5'd10);
      recv(0, "div_ovf");
      send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 6'd25, 5'd11);
      recv(0, "rem_ovf");
      send(3'd0, 32'd0, 32'h1234_5678, 6'd26, 5'd12);
      recv(0, "mul_zero");

      send(3'd0, 32'h1234_5678, 32'd9, 6'd33, 5'd17);
      recv(10, "bp");

      // Flush a DIV mid-flight, then issue a MUL straight away.
      send(3'd4, 32'd100, 32'd7, 6'd40, 5'd20);
      tick();
      tick();
      tick();
      tick();
      global_branch_signal = 1'b1;
      tick();
      global_branch_signal = 1'b0;
      void'(scb.pop_back());
      check1("flush_in_ready", in_ready, 1'b1);
      check1("flush_out_valid", out_valid, 1'b0);
      send(3'd0, 32'd3, 32'd4, 6'd41, 5'd21);
      recv(0, "after_flush");

      // Flush in DONE with out_ready high in the same cycle.
      send(3'd1, 32'h7654_3210, 32'h0000_1234, 6'd42, 5'd22);
      w = 0;
      while (!out_valid && w < 200) begin
         tick();
         w++;
      end
      check1("done_flush_pre_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      global_branch_signal = 1'b1;
      tick();
      out_ready = 1'b0;
      global_branch_signal = 1'b0;
      void'(scb.pop_front());
      check1("done_flush_valid", out_valid, 1'b0);
      check1("done_flush_in_ready", in_ready, 1'b1);

      // An issue coinciding with a flush must be dropped.
      in_valid = 1'b1;
      in_funct3 = 3'd5;
      rs1_v = 32'd50;
      rs2_v = 32'd3;
      global_branch_signal = 1'b1;
      tick();
      in_valid = 1'b0;
      global_branch_signal = 1'b0;
      check1("flush_issue_in_ready", in_ready, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         seen = seen | out_valid;
      end
      check1("flush_issue_no_output", seen, 1'b0);

      for (int k = 0; k < 10; k++) begin
         f3 = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 4) == 0) b = 32'd0;
         if ($urandom_range(0, 4) == 0) a = 32'd0;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 300));
         send(f3, a, b, 6'($urandom), 5'($urandom));
         recv(k % 3, "rnd");
      end

      // Reset in the middle of an operation clears the outputs.
      send(3'd7, 32'd1000, 32'd33, 6'd50, 5'd30);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(scb.pop_front());
      check1("midrst_in_ready", in_ready, 1'b1);
      check1("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_rd_v", out_rd_v, 32'd0);
      check("midrst_out_pd", {26'b0, out_pd}, 32'd0);
      check("midrst_out_rob", {27'b0, out_rob}, 32'd0);

      send(3'd4, 32'd100, 32'hFFFF_FFF9, 6'd51, 5'd31);
      recv(0, "post_rst_div");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
